// File: rtl/rv_pkg.sv
// Shared core definitions: architectural width, special instruction encodings
// and the fetch FSM state type.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_UNIMP = 32'hC000_1073;
    localparam logic [XLEN-1:0] INSTR_NOP   = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush. The head entry is read combinationally so
// a word written on one edge is visible on dout right after that edge.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue may accept a push only when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    assign count = count_reg;
    assign dout  = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && !flush && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from a combinational imem,
// buffers {pc, instr} pairs for decode and halts after fetching unimp.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_instr,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_instr,
    output logic             halted
);

    localparam int QAW = $clog2(QDEPTH);

    fetch_state_t     state_reg;
    fetch_state_t     state_next;
    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  pc_next;

    logic             pop;
    logic             push;
    logic [2*XLEN-1:0] q_dout;
    logic [QAW:0]     q_count;
    logic             q_empty;
    logic             q_full;

    assign imem_addr = pc_reg;
    assign out_valid = (q_count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = (state_reg == FETCH_RUN) && !redirect_valid && (!q_full || pop);
    assign out_pc    = q_dout[2*XLEN-1:XLEN];
    assign out_instr = q_dout[XLEN-1:0];
    assign halted    = (state_reg == FETCH_HALT);

    fetch_queue #(
        .WIDTH (2*XLEN),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop && !q_empty && !redirect_valid),
        .flush (redirect_valid),
        .din   ({pc_reg, imem_instr}),
        .dout  (q_dout),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (redirect_valid) begin
            // Low address bits are dropped: misaligned targets are aligned silently.
            pc_next    = {redirect_pc[XLEN-1:2], 2'b00};
            state_next = FETCH_RUN;
        end else if (push) begin
            pc_next = pc_reg + 32'd4;
            if (imem_instr == INSTR_UNIMP) begin
                state_next = FETCH_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH_RUN;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference model predicts fetched
// {pc, instr} pairs into a scoreboard queue that is compared against decode.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] UNIMP    = 32'hC000_1073;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] sb[$];
    logic [31:0] m_pc;
    logic        m_halt;
    logic        unimp_en;
    logic [31:0] unimp_addr;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted)
    );

    // Memory image: every word equals its address, except an optional unimp.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (unimp_en && a == unimp_addr) return UNIMP;
        return a;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("imem_addr", imem_addr, m_pc);
        check("halted", {31'd0, halted}, {31'd0, m_halt});
        check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            check("out_pc", out_pc, sb[0][63:32]);
            check("out_instr", out_instr, sb[0][31:0]);
        end
        $display("t=%0t addr=%08h valid=%0b pc=%08h instr=%08h halted=%0b sb=%0d",
                 $time, imem_addr, out_valid, out_pc, out_instr, halted, sb.size());
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rs);
        logic        do_pop;
        logic        do_push;
        logic [31:0] w;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        rst            = rs;
        if (rs) begin
            sb.delete();
            m_pc   = RESET_PC;
            m_halt = 1'b0;
        end else if (rv) begin
            sb.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_halt = 1'b0;
        end else begin
            do_pop  = (sb.size() > 0) && rdy;
            do_push = !m_halt && ((sb.size() < QDEPTH) || do_pop);
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                w = mem_word(m_pc);
                sb.push_back({m_pc, w});
                if (w == UNIMP) m_halt = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        rst            = 1'b1;
        unimp_en       = 1'b0;
        unimp_addr     = 32'h0000_000C;
        m_pc           = RESET_PC;
        m_halt         = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);

        // Streaming
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b0);

        // Backpressure from reset
        step(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        check("bp_addr", imem_addr, 32'h8);
        check("bp_head", out_pc, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b0);

        // Redirect while full, same-cycle ready high
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'h100, 1'b0);
        check("redir_valid0", {31'd0, out_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("redir_pc", out_pc, 32'h100);
        check("redir_addr", imem_addr, 32'h104);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0);

        // PC wrap-around
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b0);

        // Halt on unimp at 0x0C, with some backpressure while halting
        unimp_en = 1'b1;
        step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_addr", imem_addr, 32'h10);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
        check("halt_drained", {31'd0, out_valid}, 32'd0);

        // Misaligned redirect out of HALT
        step(1'b1, 1'b1, 32'h203, 1'b0);
        check("mis_halted", {31'd0, halted}, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("mis_pc", out_pc, 32'h200);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0);

        // Mid-stream reset with simultaneous redirect
        step(1'b1, 1'b1, 32'h300, 1'b1);
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_addr", imem_addr, RESET_PC);
        check("mrst_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-issue RISC-V core, directly upstream of the instruction memory. It owns the program counter, drives the memory's byte address and captures the returned word. It buffers fetched instructions in a small FIFO and hands them to decode over a valid/ready handshake. It also accepts PC redirects from branch/jump resolution and stops fetching once it fetches the `unimp` end-of-test word.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `QDEPTH`, 2: fetch queue entries (power of two, ≥2).

Ports:
- `clk`  in  1  system clock; the block uses one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_addr`  out  32  byte address to instruction memory; combinational memory, word valid same cycle.
- `imem_instr`  in  32  instruction word at `imem_addr`.
- `redirect_valid`  in  1  one-cycle pulse: replace PC, discard queued instructions.
- `redirect_pc`  in  32  redirect target.
- `out_valid`  out  1  head of queue valid.
- `out_ready`  in  1  decode accepts head.
- `out_pc`  out  32  PC of head instruction.
- `out_instr`  out  32  head instruction.
- `halted`  out  1  `unimp` fetched; fetch stopped.

## Operation

- FSM states are RUN and HALT.
- `imem_addr` = `pc` register at all times. It is not gated by state.
- `pop` = `out_valid && out_ready`.
- `push` = state RUN && !`redirect_valid` && (count < `QDEPTH` || `pop`).
- On `push`: enqueue {`pc`, `imem_instr`} and set `pc` ← `pc` + 4. PC arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- When `pc` does not advance, it holds.
- Pushing `imem_instr` == 32'hC000_1073 (`unimp`) still enqueues that word, so decode sees it. The FSM then goes RUN→HALT, and `pc` advances as usual.
- HALT: no pushes occur. Queued entries keep draining normally.
- `redirect_valid` has top priority:
  - the queue is flushed, count becomes 0, and any same-cycle pop is ignored;
  - `pc` ← {`redirect_pc`[31:2], 2'b00}, with misaligned targets silently aligned;
  - state → RUN, from either state.
- The queue is FIFO and preserves order. Simultaneous push and pop with the queue full is legal, and count stays at `QDEPTH`.
- `out_pc` and `out_instr` hold stable while `out_valid` is set and `out_ready` is low.
- `rst` has priority over redirect and applies even mid-stream.

## Timing

- Reset values:
  - `pc` = `RESET_PC`
  - queue empty
  - `out_valid` = 0
  - `out_pc` = 0, `out_instr` = 0
  - `halted` = 0
  - state RUN
  - `imem_addr` = `RESET_PC`
- Fetch-to-output latency is one cycle. A word pushed at edge N is visible on `out_*` after edge N.
- Throughput is one instruction per cycle while `out_ready` = 1.
- Redirect: after the redirect edge `out_valid` = 0 for one cycle. The target instruction appears on `out_*` one cycle later.
- `halted` is registered. It rises on the edge that pushes `unimp` and clears on the edge of `rst` or `redirect_valid`.
- Backpressure: when the queue is full and there is no pop, `imem_addr` holds its value.

## Structure

- Shared package `rv_pkg` holds:
  - `INSTR_UNIMP` = 32'hC000_1073
  - `INSTR_NOP` = 32'h0000_0013
  - the fetch state enum {`FETCH_RUN`, `FETCH_HALT`}
  - `XLEN` = 32
- Sub-module `fetch_queue`: a parameterised synchronous FIFO with width 64 ({pc, instr}) and depth `QDEPTH`. It provides push/pop/flush, `count`, `empty` and `full`.
- PC register and FSM live in `fetch_unit`.

## Test plan

- **Streaming:** after reset with `out_ready` = 1 and imem words equal to their address, `out_valid` rises at cycle 1 and `out_pc`/`out_instr` run 0x0, 0x4, 0x8, ... on consecutive cycles.
- **Backpressure:** `out_ready` = 0 for 5 cycles from reset gives queue = 2 and `imem_addr` held at 0x8. `out_pc` stays 0x0. On release, the outputs are 0x0, 0x4, 0x8, with no loss or duplication.
- **Redirect while full:** `redirect_valid` with `redirect_pc` = 0x100 and the queue full gives `out_valid` = 0 the next cycle, then `out_pc` = 0x100 and `imem_addr` = 0x104. Same-cycle `out_ready` = 1 causes no pop.
- **Halt:** `unimp` at 0x0C is delivered with `out_pc` = 0x0C, and `halted` = 1 after that push. `imem_addr` then freezes at 0x10, and no further `out_valid` follows once the queue drains.
- **Misaligned redirect in HALT:** redirect with `redirect_pc` = 0x203 gives `halted` = 0, state RUN, and next `out_pc` = 0x200.
- **Mid-stream reset:** `rst` pulsed during streaming with a redirect asserted in the same cycle gives `out_valid` = 0, `imem_addr` = `RESET_PC` and `halted` = 0 on the next cycle.
